// File: rtl/types_pkg.sv
// Shared types for the multiply/divide unit: operation encoding, FSM states,
// counter width and the instruction-decode constants that route an R-type
// instruction to the unit.
package types_pkg;

   localparam int XLEN      = 32;
   localparam int MDU_CNT_W = $clog2(XLEN) + 1;

   // RISC-V M-extension funct3 encoding
   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } mdop_e;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_BUSY = 2'b01,
      MDU_DONE = 2'b10
   } mdu_state_e;

   localparam logic [6:0] OP_R_TYPE  = 7'b011_0011;
   localparam logic [6:0] MDU_FUNCT7 = 7'b000_0001;

   // True when an instruction belongs to the multiply/divide unit
   function automatic logic is_mdu_instr(input logic [6:0] opcode, input logic [6:0] funct7);
      return (opcode == OP_R_TYPE) && (funct7 == MDU_FUNCT7);
   endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// One iteration of the shared shift/accumulate datapath.
// Multiply: radix-2 shift-add, accumulator = {partial product, multiplier}.
// Divide:   restoring division, accumulator = {remainder, quotient/dividend}.
// The divide step exists only when MUL_DIV_UNIT_DIV_EN is defined.
module mdu_shift_core #(
   parameter int XLEN = 32
) (
`ifdef MUL_DIV_UNIT_DIV_EN
   input  logic              i_is_div,
`endif
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_m,
   output logic [2*XLEN-1:0] o_acc_next
);

`ifdef MUL_DIV_UNIT_DIV_EN
   logic [XLEN:0]   w_x;
   logic [XLEN+1:0] w_y;
   logic [XLEN+1:0] w_sum;

   // Single adder shared by both ops: add for multiply, subtract for divide
   always_comb begin
      w_x   = i_is_div ? i_acc[2*XLEN-1:XLEN-1] : {1'b0, i_acc[2*XLEN-1:XLEN]};
      w_y   = i_is_div ? ~{2'b00, i_m} : {2'b00, i_m};
      w_sum = {1'b0, w_x} + w_y + {{(XLEN+1){1'b0}}, i_is_div};
   end

   // Select the next accumulator value for the active operation
   always_comb begin
      o_acc_next = i_acc;
      if (i_is_div) begin
         // sign bit clear means the shifted remainder covered the divisor
         if (!w_sum[XLEN+1])
            o_acc_next = {w_sum[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
         else
            o_acc_next = {i_acc[2*XLEN-2:0], 1'b0};
      end else begin
         if (i_acc[0])
            o_acc_next = {w_sum[XLEN:0], i_acc[XLEN-1:1]};
         else
            o_acc_next = {1'b0, i_acc[2*XLEN-1:1]};
      end
   end
`else
   logic [XLEN:0] w_sum;

   // Multiply-only adder: partial product plus multiplicand
   always_comb begin
      w_sum = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_m};
   end

   // Add when the current multiplier bit is set, then shift right
   always_comb begin
      if (i_acc[0])
         o_acc_next = {w_sum, i_acc[XLEN-1:1]};
      else
         o_acc_next = {1'b0, i_acc[2*XLEN-1:1]};
   end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Operands are reduced to magnitudes on accept, iterated one bit per cycle
// in mdu_shift_core, and sign-corrected on the last iteration.
// Optional divider: define MUL_DIV_UNIT_DIV_EN. Without it, divide/remainder
// ops complete in one cycle with an all-ones result.
module mul_div_unit #(
   parameter int XLEN         = types_pkg::XLEN,
   parameter bit SIGNED_FIXUP = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  types_pkg::mdop_e op,
   input  logic [XLEN-1:0]  a,
   input  logic [XLEN-1:0]  b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic             busy
);
   import types_pkg::*;

   // Equals MDU_CNT_W at the default width; derived locally for XLEN = 64
   localparam int               CNT_W    = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_state_e        r_state;
   mdu_state_e        w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [2*XLEN-1:0] w_acc_next;
   logic [XLEN-1:0]   r_m;
   mdop_e             r_op;
   logic              r_neg;
   logic [XLEN-1:0]   r_result;

   logic              w_accept;
   logic              w_last;
   logic              w_is_div;
   logic              w_a_sgn;
   logic              w_b_sgn;
   logic              w_a_neg;
   logic              w_b_neg;
   logic              w_res_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;
   logic [2*XLEN-1:0] w_mul_full;
   logic [XLEN-1:0]   w_final;
`ifdef MUL_DIV_UNIT_DIV_EN
   logic              w_r_is_div;
   logic              w_r_is_rem;
   logic [XLEN-1:0]   w_div_raw;
`endif

   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
      return -v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
      return -v;
   endfunction

   assign w_accept = (r_state == MDU_IDLE) && in_valid && !flush;
   assign w_last   = (r_cnt == CNT_LAST);
   assign w_is_div = op inside {DIV, DIVU, REM, REMU};

   // Operand signedness, magnitudes and sign of the final result
   always_comb begin
      w_a_sgn = 1'b0;
      w_b_sgn = 1'b0;
      if (SIGNED_FIXUP) begin
         unique case (op)
            MULH, DIV, REM: begin
               w_a_sgn = 1'b1;
               w_b_sgn = 1'b1;
            end
            MULHSU:  w_a_sgn = 1'b1;
            default: ;
         endcase
      end
      w_a_neg   = w_a_sgn & a[XLEN-1];
      w_b_neg   = w_b_sgn & b[XLEN-1];
      w_a_mag   = w_a_neg ? neg_x(a) : a;
      w_b_mag   = w_b_neg ? neg_x(b) : b;
      // remainder takes the dividend's sign; everything else the product sign
      w_res_neg = (op == REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
   end

`ifdef MUL_DIV_UNIT_DIV_EN
   // Single-cycle divide cases: divide by zero and signed overflow
   always_comb begin
      logic div_zero;
      logic div_ovf;
      div_zero      = (b == '0);
      div_ovf       = SIGNED_FIXUP && (op inside {DIV, REM}) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
      w_special     = w_is_div && (div_zero || div_ovf);
      w_special_res = '1;
      if (div_zero)
         w_special_res = (op inside {REM, REMU}) ? a : '1;
      else if (div_ovf)
         w_special_res = (op == REM) ? '0 : a;
   end
`else
   // Without a divider every divide/remainder op finishes at once with all ones
   always_comb begin
      w_special     = w_is_div;
      w_special_res = '1;
   end
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= MDU_IDLE;
      else
         r_state <= w_state_next;
   end

   // FSM next state; flush overrides accept and handshake
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = MDU_IDLE;
      end else begin
         unique case (r_state)
            MDU_IDLE: if (in_valid) w_state_next = w_special ? MDU_DONE : MDU_BUSY;
            MDU_BUSY: if (w_last)   w_state_next = MDU_DONE;
            MDU_DONE: if (out_ready) w_state_next = MDU_IDLE;
            default:  w_state_next = MDU_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      in_ready  = (r_state == MDU_IDLE);
      busy      = (r_state != MDU_IDLE);
      out_valid = (r_state == MDU_DONE);
   end

   // Iteration counter and result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_result <= '0;
      end else if (flush) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
         if (w_special)
            r_result <= w_special_res;
      end else if (r_state == MDU_BUSY) begin
         if (w_last) begin
            r_cnt    <= '0;
            r_result <= w_final;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

   // Operand capture on accept, accumulator update while iterating
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op  <= op;
         r_neg <= w_res_neg;
`ifdef MUL_DIV_UNIT_DIV_EN
         r_m   <= w_is_div ? w_b_mag : w_a_mag;
         r_acc <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
`else
         r_m   <= w_a_mag;
         r_acc <= {{XLEN{1'b0}}, w_b_mag};
`endif
      end else if (r_state == MDU_BUSY) begin
         r_acc <= w_acc_next;
      end
   end

   mdu_shift_core #(
      .XLEN (XLEN)
   ) u_core (
`ifdef MUL_DIV_UNIT_DIV_EN
      .i_is_div   (w_r_is_div),
`endif
      .i_acc      (r_acc),
      .i_m        (r_m),
      .o_acc_next (w_acc_next)
   );

`ifdef MUL_DIV_UNIT_DIV_EN
   assign w_r_is_div = r_op inside {DIV, DIVU, REM, REMU};
   assign w_r_is_rem = r_op inside {REM, REMU};
`endif

   // Sign correction and half selection applied to the final iteration
   always_comb begin
      w_mul_full = r_neg ? neg_2x(w_acc_next) : w_acc_next;
      w_final    = (r_op == MUL) ? w_mul_full[XLEN-1:0] : w_mul_full[2*XLEN-1:XLEN];
`ifdef MUL_DIV_UNIT_DIV_EN
      w_div_raw  = w_r_is_rem ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
      if (w_r_is_div)
         w_final = r_neg ? neg_x(w_div_raw) : w_div_raw;
`endif
   end

   assign result = r_result;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default types_pkg::XLEN (32), operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter SIGNED_FIXUP, default 1; 1 gives the signed ops RISC-V M semantics, 0 treats every op as unsigned.
REQ-003 SHALL have port clk, in, 1, rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n, in, 1, reset; synchronous and active-low.
REQ-005 SHALL have port flush, in, 1, aborts any in-flight op.
REQ-006 SHALL have port in_valid, in, 1, request valid.
REQ-007 SHALL have port in_ready, out, 1, unit can accept a request.
REQ-008 SHALL have port op, in, 3, mdop_e, encoded as RISC-V M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 SHALL have ports a and b, in, XLEN each, rs1 and rs2 operands.
REQ-010 SHALL have port out_valid, out, 1, result valid.
REQ-011 SHALL have port out_ready, in, 1, consumer accepts the result.
REQ-012 SHALL have port result, out, XLEN, operation result.
REQ-013 SHALL have port busy, out, 1, high in BUSY and DONE.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE; in_ready is 1 only in IDLE.
REQ-015 SHALL accept a request on the edge where in_valid && in_ready, latching op, |a| and |b| (magnitudes per signedness) and the result sign.
REQ-016 SHALL compute multiply by radix-2 shift-add over a 2*XLEN accumulator, one bit per cycle, for XLEN BUSY cycles.
REQ-017 SHALL compute divide by restoring division, one quotient bit per cycle, for XLEN BUSY cycles.
REQ-018 SHALL apply sign correction (two's-complement negate) on the BUSY->DONE edge; out_valid asserts exactly XLEN+1 cycles after the accepting edge.
REQ-019 SHALL return low XLEN bits for MUL and high XLEN bits for MULH, MULHSU and MULHU; MULHSU treats a as signed and b as unsigned.
REQ-020 SHALL handle divide by zero: quotient all ones, remainder = a; goes IDLE->DONE in 1 cycle, no BUSY.
REQ-021 SHALL handle signed overflow (DIV/REM, a = most-negative, b = -1): quotient = a, remainder 0; 1-cycle latency.
REQ-022 SHALL keep result and out_valid stable in DONE until out_ready; on out_valid && out_ready go to IDLE. There is no same-cycle re-accept, so back-to-back throughput is 1 op per XLEN+2 cycles.
REQ-023 SHALL, on flush in any state, go to IDLE on the next edge, deassert out_valid and discard the result; flush has priority over accept and handshake.
REQ-024 SHALL use an iteration counter of $clog2(XLEN)+1 bits; the counter never wraps because the terminal count forces DONE.

Reset
REQ-025 SHALL, when rst_n = 0 at a clk edge, force IDLE, out_valid 0, result 0, busy 0, counter 0; in_ready is 1 in the first cycle after reset release.
REQ-026 SHALL, on reset mid-op, abandon the op silently with no out_valid pulse; reset has priority over flush.

Configuration
REQ-027 SHALL include the divider and the REQ-020/021 logic when MUL_DIV_UNIT_DIV_EN is defined.
REQ-028 SHALL, when MUL_DIV_UNIT_DIV_EN is undefined, still accept DIV, DIVU, REM and REMU, return all ones after 1 cycle, and contain no divide datapath.

Structure
REQ-029 SHALL place mdop_e (3-bit enum), MDU_CNT_W and the MDU state enum in types_pkg; OP_R_TYPE with funct7 = 7'b000_0001 selects the unit.
REQ-030 SHALL instantiate one sub-module, mdu_shift_core (shared add/sub and shift accumulator step); the FSM, special cases and handshake stay in the top module.

Verification (XLEN = 32)
REQ-031 SHALL cover: MUL a = 7, b = 0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept.
REQ-032 SHALL cover: MULHU a = b = 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-033 SHALL cover: DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both at 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-034 SHALL cover: DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, with out_ready held 0 for 5 cycles -> result stable and in_ready 0 throughout.
REQ-035 SHALL cover: flush at BUSY cycle 10 -> IDLE next cycle, no out_valid, and a following MUL 3*4 -> 12.
REQ-036 SHALL cover: rst_n low at BUSY cycle 5 -> all outputs at reset values next edge; with MUL_DIV_UNIT_DIV_EN undefined, DIV 10/2 -> 0xFFFFFFFF after 1 cycle.
